hd63701_onchip_io: RTL and testbench
====================================

Name: hd63701_onchip_io

Overview:
Bus responder for the HD63701 core's on-chip address space. It decodes the core's AD/RW/DO bus and returns read data plus a hit flag. It contains the internal 128-byte RAM, Port 1/Port 2 data-direction and data registers, and the 16-bit free-running timer with output compare and overflow. It raises the timer interrupt requests that the interrupt sequencer consumes. It sits beside the execution unit, and its read data is muxed into the core's DI ahead of external memory.

Parameters:
RAM_BASE, 8'h80, page-0 base of internal RAM; 128 bytes, 80h–FFh.
FRC_WR_VAL, 16'hFFF8, value loaded into the counter on any write to FRCH.

Ports:
CLKp  in  1  system clock; all state updates on rising edge.
RST  in  1  asynchronous reset, active-high.
CEp  in  1  bus phase; 1 = read/idle phase, 0 = write phase (same CEp as the core).
AD  in  16  core address.
RW  in  1  core write strobe; 1 = write cycle.
DO  in  8  core write data.
RDO  out  8  read data to the DI mux; 8'h00 when hit=0.
hit  out  1  AD decodes to this block; combinational.
P1_IN  in  8  Port 1 pin inputs.
P1_OUT  out  8  Port 1 data register.
P1_DDR  out  8  Port 1 direction; 1 = output.
P2_IN  in  5  Port 2 pin inputs.
P2_OUT  out  5  Port 2 data; bit1 is replaced by OLVL when OCR output is enabled.
P2_DDR  out  5  Port 2 direction.
irq_ocf  out  1  OCF & EOCI.
irq_tof  out  1  TOF & ETOI.

Behaviour:
Address decode
- Decode requires AD[15:8]==8'h00.
- Registers: 00 DDR1, 01 DDR2, 02 PORT1, 03 PORT2, 08 TCSR, 09 FRCH, 0A FRCL, 0B OCRH, 0C OCRL.
- RAM: 80–FF.
- hit=1 for exactly these addresses. Reserved 04–07, 0D–7F give hit=0.

Reads
- RDO is combinational from AD. No wait states.
- PORTn read returns (DDR & OUT) | (~DDR & IN) per bit.
- P2 reads return 3'b111 in bits [7:5]. DDR reads return the register, upper P2 bits read as 1.
- TCSR read returns {ICF=0, OCF, TOF, EICI=0, EOCI, ETOI, IEDG=0, OLVL}.
- FRCL read returns the low-byte latch (see Timer), not the live counter.

Read commit
- Read side effects take effect on a CLKp edge with hit & CEp & ~RW. Each core access is a single CEp=1 edge.

Writes
- Commit on a CLKp edge with hit & RW.
- TCSR write updates only EOCI, ETOI, OLVL. OCF and TOF are read-only from the bus.

Timer
- FRC increments by 1 on every CLKp edge with CEp=1. It wraps FFFF→0000.
- Wrap sets TOF in the same edge. FRC==OCR after increment sets OCF.
- FRCH read commit: latches FRC[7:0] into the low-byte latch. A following FRCL read returns that latched value, giving a coherent 16-bit read.
- Any write to FRCH or FRCL loads FRC_WR_VAL. A write overrides an increment in the same edge.
- OCR write: OCRH is buffered into a temp byte; OCRL write commits {temp, DO}. This prevents a spurious compare on a half-written value.
- OLVL is copied to P2_OUT[1] on each compare match when P2_DDR[1]=1.

Flag clearing (two-step, arm bit per flag)
- A TCSR read commit with the flag=1 arms it.
- OCF clears on a subsequent OCRH/OCRL write while armed.
- TOF clears on a subsequent FRCH read while armed.
- If set and clear occur in the same edge, set wins and the arm bit is kept.
- The arm bit clears when the flag clears.

Reset values
- DDR1/DDR2 = 0; PORT1/PORT2 outputs = 0.
- FRC = 0000; OCR = FFFF; TCSR = 0; arm bits, latch and temp = 0.
- RDO = 0, irq_* = 0.
- RAM contents are undefined and not reset.
- Reset mid-operation aborts any pending two-step clear or OCR half-write.

Decomposition:
- Shared package: register offsets, TCSR bit indices, FRC_WR_VAL default.
- One natural sub-module, hd63701_timer: FRC, OCR, TCSR, latch, flags.
- The top level holds decode, ports, RAM and the read mux.

Test Plan:
- Reset → DDRs=0, FRC=0000, TCSR reads 00, irq_ocf=irq_tof=0. After 5 CEp=1 edges, FRCH/FRCL read 00/05.
- DDR1=F0, PORT1 write A5, P1_IN=3C → P1_OUT=A5, PORT1 reads AC.
- OCRH write 00, OCRL write 10, EOCI=1 → OCF and irq_ocf rise on the edge FRC becomes 0010. TCSR read then OCRL write 20 → OCF=0 next edge.
- FRC written (→FFF8), ETOI=1, 8 CEp edges → FRC=0000, TOF=1, irq_tof=1. OCRH write without a prior TCSR read leaves TOF set. TCSR read then FRCH read clears it.
- FRC=12FF when FRCH is read → reads 12. After one increment, FRCL read returns FF (latched), not 00.
- RAM write 5A to 0080 and 3C to 00FF → reads return 5A/3C. AD=0100 and 0050 give hit=0, RDO=00.

Source files
------------

// File: rtl/hd63701_onchip_io_pkg.sv
// Shared definitions for the HD63701 on-chip I/O block: register map, TCSR bit
// positions, timer load value and the page-0 address decoder.
package hd63701_onchip_io_pkg;

  localparam logic [7:0]  OFF_DDR1  = 8'h00;
  localparam logic [7:0]  OFF_DDR2  = 8'h01;
  localparam logic [7:0]  OFF_PORT1 = 8'h02;
  localparam logic [7:0]  OFF_PORT2 = 8'h03;
  localparam logic [7:0]  OFF_TCSR  = 8'h08;
  localparam logic [7:0]  OFF_FRCH  = 8'h09;
  localparam logic [7:0]  OFF_FRCL  = 8'h0A;
  localparam logic [7:0]  OFF_OCRH  = 8'h0B;
  localparam logic [7:0]  OFF_OCRL  = 8'h0C;

  localparam int TCSR_OLVL = 0;
  localparam int TCSR_IEDG = 1;
  localparam int TCSR_ETOI = 2;
  localparam int TCSR_EOCI = 3;
  localparam int TCSR_EICI = 4;
  localparam int TCSR_TOF  = 5;
  localparam int TCSR_OCF  = 6;
  localparam int TCSR_ICF  = 7;

  localparam logic [15:0] FRC_WR_VAL_DEFAULT = 16'hFFF8;
  localparam logic [7:0]  RAM_BASE_DEFAULT   = 8'h80;

  typedef enum logic [3:0] {
    SEL_NONE, SEL_DDR1, SEL_DDR2, SEL_PORT1, SEL_PORT2, SEL_TCSR,
    SEL_FRCH, SEL_FRCL, SEL_OCRH, SEL_OCRL, SEL_RAM
  } regSel_e;

  // Everything outside page 0, and the reserved holes inside it, is left to external memory.
  function automatic regSel_e decodeAddr(input logic [15:0] addr, input logic [7:0] ramBase);
    regSel_e sel;
    sel = SEL_NONE;
    if (addr[15:8] == 8'h00) begin
      if (addr[7:0] >= ramBase) begin
        sel = SEL_RAM;
      end else begin
        case (addr[7:0])
          OFF_DDR1:  sel = SEL_DDR1;
          OFF_DDR2:  sel = SEL_DDR2;
          OFF_PORT1: sel = SEL_PORT1;
          OFF_PORT2: sel = SEL_PORT2;
          OFF_TCSR:  sel = SEL_TCSR;
          OFF_FRCH:  sel = SEL_FRCH;
          OFF_FRCL:  sel = SEL_FRCL;
          OFF_OCRH:  sel = SEL_OCRH;
          OFF_OCRL:  sel = SEL_OCRL;
          default:   sel = SEL_NONE;
        endcase
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hd63701_timer.sv
// Free-running counter with output compare, overflow flags, the coherent low-byte
// latch and the buffered OCR write used by the on-chip I/O block.
module hd63701_timer
  import hd63701_onchip_io_pkg::*;
#(
  parameter logic [15:0] FRC_WR_VAL = FRC_WR_VAL_DEFAULT
) (
  input  logic        CLKp,
  input  logic        RST,
  input  logic        CEp,
  input  logic        rdTcsr_i,
  input  logic        rdFrch_i,
  input  logic        wrTcsr_i,
  input  logic        wrFrc_i,
  input  logic        wrOcrh_i,
  input  logic        wrOcrl_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  tcsr_o,
  output logic [15:0] frc_o,
  output logic [7:0]  frcLatch_o,
  output logic [15:0] ocr_o,
  output logic        ocMatch_o,
  output logic        irqOcf_o,
  output logic        irqTof_o
);

  logic [15:0] frc_q, frc_d, ocr_q, ocr_d, frcInc;
  logic [7:0]  ocrTemp_q, ocrTemp_d, frcLatch_q, frcLatch_d;
  logic        ocf_q, ocf_d, tof_q, tof_d, armOcf_q, armOcf_d, armTof_q, armTof_d;
  logic        eoci_q, eoci_d, etoi_q, etoi_d, olvl_q, olvl_d;
  logic        incEn, ocMatch, tofSet, ocfClr, tofClr;

  // A counter load suppresses that edge's increment, so it can neither match nor wrap.
  always_comb begin
    frcInc     = frc_q + 16'd1;
    incEn      = CEp & ~wrFrc_i;
    ocMatch    = incEn & (frcInc == ocr_q);
    tofSet     = incEn & (frc_q == 16'hFFFF);
    ocfClr     = (wrOcrh_i | wrOcrl_i) & armOcf_q;
    tofClr     = rdFrch_i & armTof_q;
    frc_d      = frc_q;
    ocr_d      = ocr_q;
    ocrTemp_d  = ocrTemp_q;
    frcLatch_d = frcLatch_q;
    eoci_d     = eoci_q;
    etoi_d     = etoi_q;
    olvl_d     = olvl_q;
    ocf_d      = ocf_q;
    tof_d      = tof_q;
    armOcf_d   = armOcf_q | (rdTcsr_i & ocf_q);
    armTof_d   = armTof_q | (rdTcsr_i & tof_q);
    if (wrFrc_i) frc_d = FRC_WR_VAL;
    else if (CEp) frc_d = frcInc;
    if (rdFrch_i) frcLatch_d = frc_q[7:0];
    if (wrOcrh_i) ocrTemp_d = wdata_i;
    if (wrOcrl_i) ocr_d = {ocrTemp_q, wdata_i};
    if (wrTcsr_i) begin
      eoci_d = wdata_i[TCSR_EOCI];
      etoi_d = wdata_i[TCSR_ETOI];
      olvl_d = wdata_i[TCSR_OLVL];
    end
    if (ocMatch) ocf_d = 1'b1;
    else if (ocfClr) begin
      ocf_d    = 1'b0;
      armOcf_d = 1'b0;
    end
    if (tofSet) tof_d = 1'b1;
    else if (tofClr) begin
      tof_d    = 1'b0;
      armTof_d = 1'b0;
    end
  end

  always_ff @(posedge CLKp or posedge RST) begin
    if (RST) begin
      frc_q      <= 16'h0000;
      ocr_q      <= 16'hFFFF;
      ocrTemp_q  <= 8'h00;
      frcLatch_q <= 8'h00;
      eoci_q     <= 1'b0;
      etoi_q     <= 1'b0;
      olvl_q     <= 1'b0;
      ocf_q      <= 1'b0;
      tof_q      <= 1'b0;
      armOcf_q   <= 1'b0;
      armTof_q   <= 1'b0;
    end else begin
      frc_q      <= frc_d;
      ocr_q      <= ocr_d;
      ocrTemp_q  <= ocrTemp_d;
      frcLatch_q <= frcLatch_d;
      eoci_q     <= eoci_d;
      etoi_q     <= etoi_d;
      olvl_q     <= olvl_d;
      ocf_q      <= ocf_d;
      tof_q      <= tof_d;
      armOcf_q   <= armOcf_d;
      armTof_q   <= armTof_d;
    end
  end

  always_comb begin
    tcsr_o            = 8'h00;
    tcsr_o[TCSR_ICF]  = 1'b0;
    tcsr_o[TCSR_OCF]  = ocf_q;
    tcsr_o[TCSR_TOF]  = tof_q;
    tcsr_o[TCSR_EICI] = 1'b0;
    tcsr_o[TCSR_EOCI] = eoci_q;
    tcsr_o[TCSR_ETOI] = etoi_q;
    tcsr_o[TCSR_IEDG] = 1'b0;
    tcsr_o[TCSR_OLVL] = olvl_q;
  end

  assign frc_o      = frc_q;
  assign frcLatch_o = frcLatch_q;
  assign ocr_o      = ocr_q;
  assign ocMatch_o  = ocMatch;
  assign irqOcf_o   = ocf_q & eoci_q;
  assign irqTof_o   = tof_q & etoi_q;

endmodule

// File: rtl/hd63701_onchip_io.sv
// On-chip bus responder for the HD63701: page-0 decode, Port 1/2 registers,
// 128-byte internal RAM, the timer, and the combinational read mux.
module hd63701_onchip_io
  import hd63701_onchip_io_pkg::*;
#(
  parameter logic [7:0]  RAM_BASE   = RAM_BASE_DEFAULT,
  parameter logic [15:0] FRC_WR_VAL = FRC_WR_VAL_DEFAULT
) (
  input  logic        CLKp,
  input  logic        RST,
  input  logic        CEp,
  input  logic [15:0] AD,
  input  logic        RW,
  input  logic [7:0]  DO,
  output logic [7:0]  RDO,
  output logic        hit,
  input  logic [7:0]  P1_IN,
  output logic [7:0]  P1_OUT,
  output logic [7:0]  P1_DDR,
  input  logic [4:0]  P2_IN,
  output logic [4:0]  P2_OUT,
  output logic [4:0]  P2_DDR,
  output logic        irq_ocf,
  output logic        irq_tof
);

  regSel_e     sel;
  logic        wrEn, rdEn, ocMatch;
  logic [6:0]  ramIdx;
  logic [7:0]  ram [128];
  logic [7:0]  ddr1_q, ddr1_d, port1_q, port1_d;
  logic [4:0]  ddr2_q, ddr2_d, port2_q, port2_d;
  logic [7:0]  tcsr, frcLatch;
  logic [15:0] frc, ocr;

  assign sel    = decodeAddr(AD, RAM_BASE);
  assign hit    = (sel != SEL_NONE);
  assign wrEn   = hit & RW;
  assign rdEn   = hit & CEp & ~RW;
  assign ramIdx = 7'(AD[7:0] - RAM_BASE);

  hd63701_timer #(.FRC_WR_VAL(FRC_WR_VAL)) uTimer (
    .CLKp       (CLKp),
    .RST        (RST),
    .CEp        (CEp),
    .rdTcsr_i   (rdEn & (sel == SEL_TCSR)),
    .rdFrch_i   (rdEn & (sel == SEL_FRCH)),
    .wrTcsr_i   (wrEn & (sel == SEL_TCSR)),
    .wrFrc_i    (wrEn & ((sel == SEL_FRCH) | (sel == SEL_FRCL))),
    .wrOcrh_i   (wrEn & (sel == SEL_OCRH)),
    .wrOcrl_i   (wrEn & (sel == SEL_OCRL)),
    .wdata_i    (DO),
    .tcsr_o     (tcsr),
    .frc_o      (frc),
    .frcLatch_o (frcLatch),
    .ocr_o      (ocr),
    .ocMatch_o  (ocMatch),
    .irqOcf_o   (irq_ocf),
    .irqTof_o   (irq_tof)
  );

  // A compare match drives OLVL onto P2.1 only while that pin is an output.
  always_comb begin
    ddr1_d  = ddr1_q;
    ddr2_d  = ddr2_q;
    port1_d = port1_q;
    port2_d = port2_q;
    if (wrEn) begin
      case (sel)
        SEL_DDR1:  ddr1_d  = DO;
        SEL_DDR2:  ddr2_d  = DO[4:0];
        SEL_PORT1: port1_d = DO;
        SEL_PORT2: port2_d = DO[4:0];
        default:   ;
      endcase
    end
    if (ocMatch && ddr2_q[1]) port2_d[1] = tcsr[TCSR_OLVL];
  end

  always_ff @(posedge CLKp or posedge RST) begin
    if (RST) begin
      ddr1_q  <= 8'h00;
      ddr2_q  <= 5'h00;
      port1_q <= 8'h00;
      port2_q <= 5'h00;
    end else begin
      ddr1_q  <= ddr1_d;
      ddr2_q  <= ddr2_d;
      port1_q <= port1_d;
      port2_q <= port2_d;
    end
  end

  always_ff @(posedge CLKp) begin
    if (wrEn && (sel == SEL_RAM)) ram[ramIdx] <= DO;
  end

  always_comb begin
    RDO = 8'h00;
    case (sel)
      SEL_DDR1:  RDO = ddr1_q;
      SEL_DDR2:  RDO = {3'b111, ddr2_q};
      SEL_PORT1: RDO = (ddr1_q & port1_q) | (~ddr1_q & P1_IN);
      SEL_PORT2: RDO = {3'b111, (ddr2_q & port2_q) | (~ddr2_q & P2_IN)};
      SEL_TCSR:  RDO = tcsr;
      SEL_FRCH:  RDO = frc[15:8];
      SEL_FRCL:  RDO = frcLatch;
      SEL_OCRH:  RDO = ocr[15:8];
      SEL_OCRL:  RDO = ocr[7:0];
      SEL_RAM:   RDO = ram[ramIdx];
      default:   RDO = 8'h00;
    endcase
  end

  assign P1_OUT = port1_q;
  assign P1_DDR = ddr1_q;
  assign P2_OUT = port2_q;
  assign P2_DDR = ddr2_q;

endmodule

// File: tb/tb_hd63701_onchip_io.sv
// Self-checking bench for hd63701_onchip_io: directed scenarios plus a randomized
// bus run compared against a register-level behavioural model.
module tb_hd63701_onchip_io;

  logic        CLKp = 1'b0, RST = 1'b1, CEp = 1'b0, RW = 1'b0;
  logic [15:0] AD = 16'h0004;
  logic [7:0]  DO = 8'h00, P1_IN = 8'h00;
  logic [4:0]  P2_IN = 5'h00;
  logic [7:0]  RDO, P1_OUT, P1_DDR;
  logic [4:0]  P2_OUT, P2_DDR;
  logic        hit, irq_ocf, irq_tof;
  int checks = 0, errors = 0;

  // Behavioural model state
  int mFrc, mOcr;
  logic [7:0] mTemp, mLatch, mDdr1, mP1;
  logic [4:0] mDdr2, mP2;
  logic mOcf, mTof, mEoci, mEtoi, mOlvl, mArmO, mArmT;
  logic [7:0] mRam [128];
  logic mRamOk [128];

  // Scratch used by the scenario tasks (only the initial block's call chain touches these).
  logic [7:0] r, er;
  logic h, eh, ek;

  hd63701_onchip_io dut (
    .CLKp(CLKp), .RST(RST), .CEp(CEp), .AD(AD), .RW(RW), .DO(DO), .RDO(RDO), .hit(hit),
    .P1_IN(P1_IN), .P1_OUT(P1_OUT), .P1_DDR(P1_DDR), .P2_IN(P2_IN), .P2_OUT(P2_OUT),
    .P2_DDR(P2_DDR), .irq_ocf(irq_ocf), .irq_tof(irq_tof)
  );

  always #5 CLKp = ~CLKp;

  task automatic modelReset();
    mFrc = 0; mOcr = 65535; mTemp = 0; mLatch = 0; mDdr1 = 0; mP1 = 0; mDdr2 = 0; mP2 = 0;
    mOcf = 0; mTof = 0; mEoci = 0; mEtoi = 0; mOlvl = 0; mArmO = 0; mArmT = 0;
  endtask

  task automatic modelRead(input logic [15:0] addr, output logic hv, output logic [7:0] d, output logic known);
    logic [7:0] a;
    hv = 0; d = 0; known = 1; a = addr[7:0];
    if (addr[15:8] == 8'h00) begin
      hv = 1;
      if (a >= 8'h80) begin
        d = mRam[int'(a) - 128]; known = mRamOk[int'(a) - 128];
      end else begin
        case (a)
          8'h00: d = mDdr1;
          8'h01: d = {3'b111, mDdr2};
          8'h02: for (int b = 0; b < 8; b++) d[b] = mDdr1[b] ? mP1[b] : P1_IN[b];
          8'h03: begin d = 8'hE0; for (int b = 0; b < 5; b++) d[b] = mDdr2[b] ? mP2[b] : P2_IN[b]; end
          8'h08: d = (mOcf ? 8'h40 : 8'h00) | (mTof ? 8'h20 : 8'h00) | (mEoci ? 8'h08 : 8'h00)
                   | (mEtoi ? 8'h04 : 8'h00) | (mOlvl ? 8'h01 : 8'h00);
          8'h09: d = 8'(mFrc / 256);
          8'h0A: d = mLatch;
          8'h0B: d = 8'(mOcr / 256);
          8'h0C: d = 8'(mOcr % 256);
          default: hv = 0;
        endcase
      end
    end
  endtask

  // One clock edge of the model, expressed in terms of register-level effects.
  task automatic modelEdge(input logic ce, input logic rw, input logic [15:0] addr, input logic [7:0] data);
    logic hv, k, rd, wr, frcLoad, match, wrap, armO, armT, oldOlvl;
    logic [7:0] d, a;
    logic [4:0] oldDdr2;
    int oldFrc;
    modelRead(addr, hv, d, k);
    rd = hv && ce && !rw; wr = hv && rw; a = addr[7:0];
    oldFrc = mFrc; oldOlvl = mOlvl; oldDdr2 = mDdr2;
    frcLoad = wr && (a == 8'h09 || a == 8'h0A);
    match = ce && !frcLoad && (((oldFrc + 1) % 65536) == mOcr);
    wrap = ce && !frcLoad && (oldFrc == 65535);
    armO = mArmO || (rd && a == 8'h08 && mOcf);
    armT = mArmT || (rd && a == 8'h08 && mTof);
    if (match) begin mOcf = 1; mArmO = armO; end
    else if (wr && (a == 8'h0B || a == 8'h0C) && mArmO) begin mOcf = 0; mArmO = 0; end
    else mArmO = armO;
    if (wrap) begin mTof = 1; mArmT = armT; end
    else if (rd && a == 8'h09 && mArmT) begin mTof = 0; mArmT = 0; end
    else mArmT = armT;
    if (rd && a == 8'h09) mLatch = 8'(oldFrc % 256);
    if (frcLoad) mFrc = 65528;
    else if (ce) mFrc = (oldFrc + 1) % 65536;
    if (wr) begin
      case (a)
        8'h00: mDdr1 = data;
        8'h01: mDdr2 = data[4:0];
        8'h02: mP1 = data;
        8'h03: mP2 = data[4:0];
        8'h08: begin mEoci = data[3]; mEtoi = data[2]; mOlvl = data[0]; end
        8'h0B: mTemp = data;
        8'h0C: mOcr = int'(mTemp) * 256 + int'(data);
        default: if (a >= 8'h80) begin mRam[int'(a) - 128] = data; mRamOk[int'(a) - 128] = 1; end
      endcase
    end
    if (match && oldDdr2[1]) mP2[1] = oldOlvl;
  endtask

  // Drives one bus cycle; returns what the DUT showed before the edge and what the model predicts.
  task automatic busCycle(input logic ce, input logic rw, input logic [15:0] addr, input logic [7:0] data,
                          output logic [7:0] obsRdo, output logic obsHit,
                          output logic [7:0] expRdo, output logic expHit, output logic expKnown);
    @(negedge CLKp);
    CEp = ce; RW = rw; AD = addr; DO = data;
    #1;
    obsRdo = RDO; obsHit = hit;
    modelRead(addr, expHit, expRdo, expKnown);
    @(posedge CLKp);
    modelEdge(ce, rw, addr, data);
    #1;
  endtask

  task automatic doReset();
    @(negedge CLKp);
    RST = 1; CEp = 0; RW = 0; AD = 16'h0004; DO = 0;
    repeat (2) @(negedge CLKp);
    modelReset();
    RST = 0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if ({P1_DDR, P2_DDR, P1_OUT, P2_OUT} !== 26'h0) begin errors++; $display("[TB] FAIL reset_ports got %h want 0", {P1_DDR, P2_DDR, P1_OUT, P2_OUT}); end
    checks++; if ({irq_ocf, irq_tof} !== 2'b00) begin errors++; $display("[TB] FAIL reset_irq got %b want 00", {irq_ocf, irq_tof}); end
    busCycle(0, 0, 16'h0008, 0, r, h, er, eh, ek);
    checks++; if ({h, r} !== 9'h100) begin errors++; $display("[TB] FAIL reset_tcsr got %h want 100", {h, r}); end
    busCycle(0, 0, 16'h0000, 0, r, h, er, eh, ek);
    checks++; if ({h, r} !== 9'h100) begin errors++; $display("[TB] FAIL reset_ddr1 got %h want 100", {h, r}); end
    repeat (5) busCycle(1, 0, 16'h0004, 0, r, h, er, eh, ek);
    busCycle(1, 0, 16'h0009, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h00) begin errors++; $display("[TB] FAIL reset_frch got %h want 00", r); end
    busCycle(1, 0, 16'h000A, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h05) begin errors++; $display("[TB] FAIL reset_frcl got %h want 05", r); end
  endtask

  task automatic test_ports();
    doReset();
    P1_IN = 8'h3C; P2_IN = 5'h0A;
    busCycle(0, 1, 16'h0000, 8'hF0, r, h, er, eh, ek);
    busCycle(0, 1, 16'h0002, 8'hA5, r, h, er, eh, ek);
    busCycle(0, 1, 16'h0001, 8'h1A, r, h, er, eh, ek);
    busCycle(0, 1, 16'h0003, 8'h15, r, h, er, eh, ek);
    checks++; if ({P1_OUT, P1_DDR} !== 16'hA5F0) begin errors++; $display("[TB] FAIL p1_regs got %h want A5F0", {P1_OUT, P1_DDR}); end
    checks++; if ({P2_OUT, P2_DDR} !== 10'h2BA) begin errors++; $display("[TB] FAIL p2_regs got %h want 2BA", {P2_OUT, P2_DDR}); end
    busCycle(1, 0, 16'h0002, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'hAC) begin errors++; $display("[TB] FAIL port1_read got %h want AC", r); end
    busCycle(1, 0, 16'h0003, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'hF0) begin errors++; $display("[TB] FAIL port2_read got %h want F0", r); end
    busCycle(1, 0, 16'h0001, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'hFA) begin errors++; $display("[TB] FAIL ddr2_read got %h want FA", r); end
  endtask

  task automatic test_ocf();
    doReset();
    busCycle(0, 1, 16'h000B, 8'h00, r, h, er, eh, ek);
    busCycle(0, 1, 16'h000C, 8'h10, r, h, er, eh, ek);
    busCycle(0, 1, 16'h0001, 8'h02, r, h, er, eh, ek);
    busCycle(0, 1, 16'h0008, 8'h09, r, h, er, eh, ek);
    for (int i = 1; i <= 16; i++) begin
      busCycle(1, 0, 16'h0004, 0, r, h, er, eh, ek);
      checks++; if (irq_ocf !== (i == 16)) begin errors++; $display("[TB] FAIL ocf_rise edge %0d got %b want %b", i, irq_ocf, i == 16); end
    end
    checks++; if (P2_OUT !== 5'h02) begin errors++; $display("[TB] FAIL olvl_p2 got %h want 02", P2_OUT); end
    busCycle(0, 1, 16'h000B, 8'h00, r, h, er, eh, ek);
    checks++; if (irq_ocf !== 1'b1) begin errors++; $display("[TB] FAIL ocf_unarmed got %b want 1", irq_ocf); end
    busCycle(1, 0, 16'h0008, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h49) begin errors++; $display("[TB] FAIL ocf_tcsr got %h want 49", r); end
    busCycle(0, 1, 16'h000C, 8'h20, r, h, er, eh, ek);
    checks++; if (irq_ocf !== 1'b0) begin errors++; $display("[TB] FAIL ocf_clear got %b want 0", irq_ocf); end
    busCycle(0, 0, 16'h0008, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h09) begin errors++; $display("[TB] FAIL ocf_tcsr_after got %h want 09", r); end
  endtask

  task automatic test_tof();
    doReset();
    busCycle(0, 1, 16'h0008, 8'h04, r, h, er, eh, ek);
    busCycle(0, 1, 16'h0009, 8'h00, r, h, er, eh, ek);
    for (int i = 1; i <= 8; i++) begin
      busCycle(1, 0, 16'h0004, 0, r, h, er, eh, ek);
      checks++; if (irq_tof !== (i == 8)) begin errors++; $display("[TB] FAIL tof_rise edge %0d got %b want %b", i, irq_tof, i == 8); end
    end
    busCycle(0, 1, 16'h000B, 8'h00, r, h, er, eh, ek);
    busCycle(1, 0, 16'h0009, 0, r, h, er, eh, ek);
    checks++; if (irq_tof !== 1'b1) begin errors++; $display("[TB] FAIL tof_unarmed got %b want 1", irq_tof); end
    busCycle(1, 0, 16'h0008, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h64) begin errors++; $display("[TB] FAIL tof_tcsr got %h want 64", r); end
    busCycle(1, 0, 16'h0009, 0, r, h, er, eh, ek);
    checks++; if (irq_tof !== 1'b0) begin errors++; $display("[TB] FAIL tof_clear got %b want 0", irq_tof); end
    busCycle(0, 0, 16'h0008, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h44) begin errors++; $display("[TB] FAIL tof_tcsr_after got %h want 44", r); end
  endtask

  task automatic test_latch();
    doReset();
    repeat (16'h12FF) busCycle(1, 0, 16'h0004, 0, r, h, er, eh, ek);
    busCycle(1, 0, 16'h0009, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h12) begin errors++; $display("[TB] FAIL latch_frch got %h want 12", r); end
    busCycle(1, 0, 16'h000A, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'hFF) begin errors++; $display("[TB] FAIL latch_frcl got %h want FF", r); end
    busCycle(1, 0, 16'h0009, 0, r, h, er, eh, ek);
    busCycle(1, 0, 16'h000A, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h01) begin errors++; $display("[TB] FAIL latch_frcl2 got %h want 01", r); end
  endtask

  task automatic test_reset_abort();
    doReset();
    busCycle(0, 1, 16'h000B, 8'h12, r, h, er, eh, ek);
    doReset();
    busCycle(0, 1, 16'h000C, 8'h34, r, h, er, eh, ek);
    busCycle(0, 0, 16'h000B, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h00) begin errors++; $display("[TB] FAIL abort_ocrh got %h want 00", r); end
    busCycle(0, 0, 16'h000C, 0, r, h, er, eh, ek);
    checks++; if (r !== 8'h34) begin errors++; $display("[TB] FAIL abort_ocrl got %h want 34", r); end
  endtask

  task automatic test_ram_decode();
    logic [15:0] misses [6];
    misses = '{16'h0100, 16'h0050, 16'h0004, 16'h000D, 16'h007F, 16'h0180};
    busCycle(0, 1, 16'h0080, 8'h5A, r, h, er, eh, ek);
    busCycle(0, 1, 16'h00FF, 8'h3C, r, h, er, eh, ek);
    busCycle(0, 0, 16'h0080, 0, r, h, er, eh, ek);
    checks++; if ({h, r} !== 9'h15A) begin errors++; $display("[TB] FAIL ram_80 got %h want 15A", {h, r}); end
    busCycle(0, 0, 16'h00FF, 0, r, h, er, eh, ek);
    checks++; if ({h, r} !== 9'h13C) begin errors++; $display("[TB] FAIL ram_ff got %h want 13C", {h, r}); end
    foreach (misses[i]) begin
      busCycle(0, 0, misses[i], 0, r, h, er, eh, ek);
      checks++; if ({h, r} !== 9'h000) begin errors++; $display("[TB] FAIL miss_%h got %h want 000", misses[i], {h, r}); end
    end
  endtask

  task automatic test_random();
    logic [15:0] addrs [9];
    logic [15:0] a;
    logic ce, rw;
    addrs = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0008, 16'h0009, 16'h000A, 16'h000B, 16'h000C};
    doReset();
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 9))
        0: a = 16'($urandom);
        1, 2: a = 16'h0080 + 16'($urandom_range(0, 7));
        default: a = addrs[$urandom_range(0, 8)];
      endcase
      rw = ($urandom_range(0, 3) == 0);
      ce = rw ? 1'($urandom) : ($urandom_range(0, 7) != 0);
      P1_IN = 8'($urandom); P2_IN = 5'($urandom);
      busCycle(ce, rw, a, 8'($urandom), r, h, er, eh, ek);
      if (ek) begin
        checks++; if ({h, r} !== {eh, er}) begin errors++; $display("[TB] FAIL rand_read n=%0d ad=%h got %h want %h", n, a, {h, r}, {eh, er}); end
      end
      checks++;
      if ({P1_OUT, P1_DDR, P2_OUT, P2_DDR, irq_ocf, irq_tof} !== {mP1, mDdr1, mP2, mDdr2, mOcf & mEoci, mTof & mEtoi}) begin
        errors++;
        $display("[TB] FAIL rand_state n=%0d got %h want %h", n, {P1_OUT, P1_DDR, P2_OUT, P2_DDR, irq_ocf, irq_tof},
                 {mP1, mDdr1, mP2, mDdr2, mOcf & mEoci, mTof & mEtoi});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin mRamOk[i] = 0; mRam[i] = 0; end
    modelReset();
    test_reset();
    test_ports();
    test_ocf();
    test_tof();
    test_latch();
    test_reset_abort();
    test_ram_decode();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
